// File: rtl/label_scanner_pkg.sv
// Shared definitions for the label scanner: opcode and label-type codes,
// FSM state encoding and the saturating label counter helper.
package label_scanner_pkg;

  localparam logic [7:0]  OP_LB       = 8'h01;
  localparam logic [7:0]  LBTYPE_CODE = 8'h01;
  localparam logic [7:0]  LBTYPE_DATA = 8'h02;
  localparam logic [7:0]  LBTYPE_BSS  = 8'h03;
  localparam logic [12:0] LABEL_MAX   = 13'd4096;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    FLUSH,
    FIN
  } state_e;

  function automatic logic [12:0] sat_inc(input logic [12:0] c);
    return (c == LABEL_MAX) ? c : c + 13'd1;
  endfunction

endpackage

// File: rtl/label_scanner.sv
// Scans program memory for LB instructions and emits one label-table entry
// (id, type, base, count) per label. Optional macro: LBSCAN_ORDER_CHECK_EN.
module label_scanner
  import label_scanner_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] prog_len,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_data,
  output logic [11:0] lbidw,
  output logic [7:0]  lbTypew,
  output logic [15:0] basew,
  output logic [15:0] countw,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [12:0] label_count
);

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d, len_q, len_d, obase_q, obase_d;
  logic [11:0] oid_q, oid_d;
  logic [7:0]  otype_q, otype_d;
  logic        open_q, open_d;
  logic [15:0] mem_addr_q, mem_addr_d, basew_q, basew_d, countw_q, countw_d;
  logic [11:0] lbidw_q, lbidw_d;
  logic [7:0]  lbTypew_q, lbTypew_d;
  logic        mem_re_q, mem_re_d, we_q, we_d, busy_q, busy_d;
  logic        done_q, done_d, err_q, err_d;
  logic [12:0] cnt_q, cnt_d;
  logic        is_lb, viol, emit;
  logic [15:0] ptr_inc;
  logic        unused_bits;

  assign is_lb       = (mem_data[31:24] == OP_LB);
  assign ptr_inc     = ptr_q + 16'd1;
  assign unused_bits = ^mem_data[23:20];

`ifdef LBSCAN_ORDER_CHECK_EN
  // Label ids within one scan must strictly increase.
  assign viol = is_lb && open_q && (mem_data[11:0] <= oid_q);
`else
  assign viol = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    obase_d    = obase_q;
    oid_d      = oid_q;
    otype_d    = otype_q;
    open_d     = open_q;
    mem_addr_d = mem_addr_q;
    mem_re_d   = 1'b0;
    we_d       = 1'b0;
    lbidw_d    = lbidw_q;
    lbTypew_d  = lbTypew_q;
    basew_d    = basew_q;
    countw_d   = countw_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    emit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d  = 16'd0;
          len_d  = prog_len;
          open_d = 1'b0;
          cnt_d  = 13'd0;
          err_d  = 1'b0;
          busy_d = 1'b1;
          if (prog_len == 16'd0) begin
            state_d = FLUSH;
          end else begin
            state_d    = READ;
            mem_re_d   = 1'b1;
            mem_addr_d = 16'd0;
          end
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        // A new LB closes the open label: its extent ends at this word.
        if (is_lb && open_q) begin
          emit      = 1'b1;
          lbidw_d   = oid_q;
          lbTypew_d = otype_q;
          basew_d   = obase_q;
          countw_d  = ptr_q - obase_q;
        end
        if (viol) begin
          err_d   = 1'b1;
          open_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          if (is_lb) begin
            open_d  = 1'b1;
            obase_d = ptr_inc;
            oid_d   = mem_data[11:0];
            otype_d = mem_data[19:12];
          end
          ptr_d = ptr_inc;
          if (ptr_inc == len_q) begin
            state_d = FLUSH;
          end else begin
            state_d    = READ;
            mem_re_d   = 1'b1;
            mem_addr_d = ptr_inc;
          end
        end
      end
      FLUSH: begin
        if (open_q) begin
          emit      = 1'b1;
          lbidw_d   = oid_q;
          lbTypew_d = otype_q;
          basew_d   = obase_q;
          countw_d  = len_q - obase_q;
        end
        open_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (emit) begin
      we_d  = 1'b1;
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      open_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      we_q       <= 1'b0;
      lbidw_q    <= '0;
      lbTypew_q  <= '0;
      basew_q    <= '0;
      countw_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      open_q     <= open_d;
      mem_addr_q <= mem_addr_d;
      mem_re_q   <= mem_re_d;
      we_q       <= we_d;
      lbidw_q    <= lbidw_d;
      lbTypew_q  <= lbTypew_d;
      basew_q    <= basew_d;
      countw_q   <= countw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Scan bookkeeping is always initialised on an accepted start.
  always_ff @(posedge clk) begin
    ptr_q   <= ptr_d;
    len_q   <= len_d;
    obase_q <= obase_d;
    oid_q   <= oid_d;
    otype_q <= otype_d;
  end

  assign mem_addr    = mem_addr_q;
  assign mem_re      = mem_re_q;
  assign we          = we_q;
  assign lbidw       = lbidw_q;
  assign lbTypew     = lbTypew_q;
  assign basew       = basew_q;
  assign countw      = countw_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign label_count = cnt_q;

endmodule

// File: tb/tb_label_scanner.sv
// Self-checking bench for label_scanner: table of scans with a write scoreboard,
// plus mid-scan reset, counter saturation and (with LBSCAN_ORDER_CHECK_EN) ordering.
module tb_label_scanner;
  import label_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] prog_len, mem_addr;
  logic        mem_re, we, busy, done, err;
  logic [31:0] mem_data;
  logic [11:0] lbidw;
  logic [7:0]  lbTypew;
  logic [15:0] basew, countw;
  logic [12:0] label_count;

  label_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_data(mem_data),
    .lbidw(lbidw), .lbTypew(lbTypew), .basew(basew), .countw(countw),
    .we(we), .busy(busy), .done(done), .err(err), .label_count(label_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8192];
  always @(posedge clk) if (mem_re) mem_data <= mem[mem_addr[12:0]];

  int n_vec = 0, n_err = 0, done_cnt = 0;
  logic [51:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] lbw(input logic [11:0] id, input logic [7:0] ty);
    return {OP_LB, 4'h0, ty, id};
  endfunction

  function automatic logic [51:0] ent(input logic [11:0] id, input logic [7:0] ty,
                                      input logic [15:0] b, input logic [15:0] c);
    return {id, ty, b, c};
  endfunction

  // Scoreboard: every write pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_we: got write %0h expected none", {lbidw, lbTypew, basew, countw});
      end else begin
        check("write_entry", {lbidw, lbTypew, basew, countw}, exp_q.pop_front());
      end
    end
  end

  typedef struct packed {
    logic [15:0]       len;
    logic [7:0][31:0]  words;
    logic [1:0]        nexp;
    logic [1:0][51:0]  exps;
    logic [12:0]       cnt;
  } vec_t;

  task automatic run_scan(input int len, input int exp_lat, input logic [12:0] exp_cnt,
                          input logic exp_err);
    int k;
    int d0;
    d0 = done_cnt;
    k = 0;
    prog_len = len[15:0];
    start = 1'b1;
    while (k < 2 * len + 60) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (k == 1) check("busy_after_start", busy, 1'b1);
      if (done) break;
    end
    check("done_seen", done, 1'b1);
    if (exp_lat >= 0) check("done_latency", k, exp_lat);
    check("busy_at_done", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("label_count", label_count, exp_cnt);
    check("err_flag", err, exp_err);
    check("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {mem_addr, mem_re, we, busy, done, err, lbidw, lbTypew, basew, countw, label_count}, '0);
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 8; i++) mem[i] = v.words[i];
  endtask

  localparam logic [31:0] NOP_A = 32'h0201_5123;
  localparam logic [31:0] NOP_B = 32'hFF02_7ABC;

  vec_t vecs [6];

  initial begin
    int d0;
    int nlb;
    vec_t v;
    for (int i = 0; i < 8192; i++) mem[i] = NOP_A;

    v = '0; v.len = 16'd6;
    v.words = {NOP_A, NOP_B, NOP_A, NOP_B, lbw(12'd1, LBTYPE_DATA), NOP_B, NOP_A, lbw(12'd0, LBTYPE_CODE)};
    v.nexp = 2'd2; v.exps = {ent(12'd1, LBTYPE_DATA, 16'd4, 16'd2), ent(12'd0, LBTYPE_CODE, 16'd1, 16'd2)};
    v.cnt = 13'd2; vecs[0] = v;
    v = '0; v.len = 16'd0; v.words = {8{lbw(12'd3, LBTYPE_CODE)}}; v.cnt = 13'd0; vecs[1] = v;
    v = '0; v.len = 16'd4;
    v.words = {NOP_A, NOP_A, NOP_A, NOP_A, lbw(12'd7, LBTYPE_DATA), NOP_B, NOP_A, NOP_B};
    v.nexp = 2'd1; v.exps = {52'd0, ent(12'd7, LBTYPE_DATA, 16'd4, 16'd0)}; v.cnt = 13'd1; vecs[2] = v;
    v = '0; v.len = 16'd3;
    v.words = {NOP_A, NOP_A, NOP_A, NOP_A, NOP_A, NOP_B, lbw(12'd9, LBTYPE_DATA), lbw(12'd2, LBTYPE_CODE)};
    v.nexp = 2'd2; v.exps = {ent(12'd9, LBTYPE_DATA, 16'd2, 16'd1), ent(12'd2, LBTYPE_CODE, 16'd1, 16'd0)};
    v.cnt = 13'd2; vecs[3] = v;
    v = '0; v.len = 16'd5; v.words = {NOP_A, NOP_B, NOP_A, NOP_B, NOP_A, NOP_B, NOP_A, NOP_B};
    v.cnt = 13'd0; vecs[4] = v;
    v = '0; v.len = 16'd3;
    v.words = {NOP_A, NOP_A, NOP_A, NOP_A, NOP_A, NOP_B, NOP_A, lbw(12'h0AB, LBTYPE_BSS)};
    v.nexp = 2'd1; v.exps = {52'd0, ent(12'h0AB, LBTYPE_BSS, 16'd1, 16'd2)}; v.cnt = 13'd1; vecs[5] = v;

    rst_n = 1'b0; start = 1'b0; prog_len = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      load_vec(vecs[t]);
      for (int e = 0; e < int'(vecs[t].nexp); e++) exp_q.push_back(vecs[t].exps[e]);
      run_scan(int'(vecs[t].len), 2 * int'(vecs[t].len) + 2, vecs[t].cnt, 1'b0);
    end

    // Reset during the second READ aborts the scan with no write and no done.
    load_vec(vecs[0]);
    d0 = done_cnt;
    prog_len = vecs[0].len;
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_re && mem_addr == 16'd1) break;
    end
    check("second_read_seen", {mem_re, mem_addr}, {1'b1, 16'd1});
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("midscan_reset_outputs");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midscan_no_done", done_cnt - d0, 0);
    check_all_zero("after_reset_idle");
    for (int e = 0; e < 2; e++) exp_q.push_back(vecs[0].exps[e]);
    run_scan(6, 14, 13'd2, 1'b0);

`ifdef LBSCAN_ORDER_CHECK_EN
    for (int i = 0; i < 8; i++) mem[i] = NOP_A;
    mem[0] = lbw(12'd5, LBTYPE_CODE);
    mem[2] = lbw(12'd3, LBTYPE_DATA);
    exp_q.push_back(ent(12'd5, LBTYPE_CODE, 16'd1, 16'd1));
    run_scan(4, 7, 13'd1, 1'b1);
    mem[2] = NOP_B;
    exp_q.push_back(ent(12'd5, LBTYPE_CODE, 16'd1, 16'd3));
    run_scan(4, 10, 13'd1, 1'b0);
`else
    // Every word is an LB: 4100 writes, counter saturates at 4096.
    nlb = 4100;
    for (int i = 0; i < nlb; i++) mem[i] = lbw(i[11:0], LBTYPE_CODE);
    for (int i = 1; i <= nlb; i++) exp_q.push_back(ent(12'(i - 1), LBTYPE_CODE, 16'(i), 16'd0));
    run_scan(nlb, 2 * nlb + 2, LABEL_MAX, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
